// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack port and the decoder valid/ready port.
// master = fetch stage, slave = memory/decoder side.
interface instr_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              id_ready;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid,
        input  imem_ack, imem_rdata, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid,
        output imem_ack, imem_rdata, id_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// KGPRISC fetch stage: PC, req/ack instruction fetch, valid/ready hand-off to the decoder.
// Optional MISALIGN_CHK_EN: misaligned redirect raises a sticky fetch_fault and stops fetching.
module instr_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    instr_fetch_if.master     bus,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              valid_q, valid_d;
    logic              kill_q, kill_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] tgt_s;
    logic              misalign_s;
    logic              imem_req_s;

`ifdef MISALIGN_CHK_EN
    assign tgt_s      = redirect_pc;
    assign misalign_s = redirect & (redirect_pc[1:0] != 2'b00);
`else
    assign tgt_s      = redirect_pc & ~{{(ADDR_W-2){1'b0}}, 2'b11};
    assign misalign_s = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            instr_q <= 32'h0000_0000;
            ipc_q   <= {ADDR_W{1'b0}};
            valid_q <= 1'b0;
            kill_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            kill_q  <= kill_d;
            fault_q <= fault_d;
        end
    end

    // Next-state and datapath update; redirect takes priority in every state
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        kill_d  = kill_q;
        fault_d = fault_q | misalign_s;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d = tgt_s;
                    if (start && !misalign_s && !fault_q) begin
                        state_d = REQ;
                        addr_d  = tgt_s;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (start && !fault_q) begin
                    state_d = REQ;
                    addr_d  = pc_q;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (bus.imem_ack) begin
                    if (kill_q || redirect) begin
                        // Stale word: drop it and re-issue from the current target
                        kill_d = 1'b0;
                        pc_d   = redirect ? tgt_s : pc_q;
                        addr_d = redirect ? tgt_s : pc_q;
                        if (misalign_s || fault_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d = REQ;
                        end
                    end else begin
                        instr_d = bus.imem_rdata;
                        ipc_d   = addr_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + {{(ADDR_W-3){1'b0}}, 3'd4};
                        state_d = HOLD;
                    end
                end else if (redirect) begin
                    pc_d   = tgt_s;
                    kill_d = 1'b1;
                end else begin
                    kill_d = kill_q;
                end
            end
            HOLD: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    pc_d    = tgt_s;
                    if (start && !misalign_s) begin
                        state_d = REQ;
                        addr_d  = tgt_s;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.id_ready) begin
                    valid_d = 1'b0;
                    if (start) begin
                        state_d = REQ;
                        addr_d  = pc_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                kill_d  = 1'b0;
            end
        endcase
    end

    // Output decode: only the memory request is combinational
    always_comb begin
        imem_req_s = (state_q == REQ);
    end

    assign bus.imem_req    = imem_req_s;
    assign bus.imem_addr   = addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = ipc_q;
    assign bus.instr_valid = valid_q;
    assign pc              = pc_q;
    assign fetch_fault     = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: memory model returns 32'h0AA0_0004 + address,
// directed scenarios push expected deliveries, a negedge monitor pops and compares.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0000_0000;
    logic [31:0] pc;
    logic        fetch_fault;
    logic        start_w = 1'b0;
    logic        redirect_w = 1'b0;
    logic [31:0] redirect_pc_w = 32'h0000_0000;
    logic [31:0] pc_w;
    logic        fetch_fault_w;

    int n_chk = 0;
    int n_fail = 0;
    int deliv_cnt = 0;
    int mem_lat = 0;
    logic [63:0] exp_q[$];

    instr_fetch_if #(.ADDR_W(32)) bus ();
    instr_fetch_if #(.ADDR_W(32)) bus_w ();

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .redirect(redirect),
        .redirect_pc(redirect_pc), .bus(bus), .pc(pc), .fetch_fault(fetch_fault)
    );

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start_w), .redirect(redirect_w),
        .redirect_pc(redirect_pc_w), .bus(bus_w), .pc(pc_w), .fetch_fault(fetch_fault_w)
    );

    // zero-wait memory and always-ready decoder for the wrap instance
    assign bus_w.imem_ack   = bus_w.imem_req;
    assign bus_w.imem_rdata = 32'h1234_5678;
    assign bus_w.id_ready   = 1'b1;

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(logic [31:0] ins, logic [31:0] ipc);
        exp_q.push_back({ins, ipc});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        redirect = 1'b0;
        bus.id_ready = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    // instruction memory: ack after mem_lat wait cycles, data = 0x0AA00004 + addr
    initial begin
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0000_0000;
        forever begin
            int cnt;
            @(negedge clk);
            if (!rst_n || !bus.imem_req) begin
                cnt = 0;
                bus.imem_ack = 1'b0;
            end else if (cnt >= mem_lat) begin
                cnt = 0;
                bus.imem_ack = 1'b1;
                bus.imem_rdata = 32'h0AA0_0004 + bus.imem_addr;
            end else begin
                cnt++;
                bus.imem_ack = 1'b0;
            end
        end
    end

    // delivery monitor: a handshake completes on the next rising edge
    initial begin
        forever begin
            logic [63:0] e;
            @(negedge clk);
            if (rst_n && bus.instr_valid && bus.id_ready && !redirect) begin
                deliv_cnt++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_delivery: got pc %h instr %h expected none",
                             bus.instr_pc, bus.instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("deliv_instr", bus.instr, e[63:32]);
                    chk("deliv_pc", bus.instr_pc, e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.id_ready = 1'b0;
        // reset state
        do_reset();
        chk("rst_pc", pc, 32'h0000_0000);
        chk("rst_addr", bus.imem_addr, 32'h0000_0000);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_instr", bus.instr, 32'h0000_0000);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        chk("rst_w_pc", pc_w, 32'hFFFF_FFFC);

        // 1: streaming, one instruction every 2 cycles
        mem_lat = 0;
        for (int i = 0; i < 5; i++) push(32'h0AA0_0004 + 32'(i * 4), 32'(i * 4));
        bus.id_ready = 1'b1;
        start = 1'b1;
        cyc(1);
        chk("t1_first_req", {31'd0, bus.imem_req}, 32'd1);
        chk("t1_first_addr", bus.imem_addr, 32'h0000_0000);
        cyc(9);
        start = 1'b0;
        cyc(3);
        chk("t1_deliv_cnt", 32'(deliv_cnt), 32'd5);
        chk("t1_pc", pc, 32'h0000_0014);
        chk("t1_idle_req", {31'd0, bus.imem_req}, 32'd0);

        // 2: decoder stall holds the instruction
        do_reset();
        push(32'h0AA0_0004, 32'h0000_0000);
        push(32'h0AA0_0008, 32'h0000_0004);
        start = 1'b1;
        cyc(2);
        for (int i = 0; i < 5; i++) begin
            chk("t2_instr", bus.instr, 32'h0AA0_0004);
            chk("t2_ipc", bus.instr_pc, 32'h0000_0000);
            chk("t2_valid", {31'd0, bus.instr_valid}, 32'd1);
            chk("t2_noreq", {31'd0, bus.imem_req}, 32'd0);
            chk("t2_pc", pc, 32'h0000_0004);
            cyc(1);
        end
        bus.id_ready = 1'b1;
        cyc(1);
        chk("t2_req", {31'd0, bus.imem_req}, 32'd1);
        chk("t2_addr", bus.imem_addr, 32'h0000_0004);
        start = 1'b0;
        cyc(3);

        // 3: redirect in REQ two cycles before ack
        do_reset();
        mem_lat = 2;
        push(32'h0AA0_0044, 32'h0000_0040);
        bus.id_ready = 1'b1;
        start = 1'b1;
        cyc(1);
        chk("t3_addr0", bus.imem_addr, 32'h0000_0000);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0040;
        cyc(1);
        redirect = 1'b0;
        cyc(2);
        chk("t3_req", {31'd0, bus.imem_req}, 32'd1);
        chk("t3_addr", bus.imem_addr, 32'h0000_0040);
        chk("t3_nodata", {31'd0, bus.instr_valid}, 32'd0);
        start = 1'b0;
        cyc(6);
        chk("t3_pc", pc, 32'h0000_0044);
        chk("t3_idle", {31'd0, bus.imem_req}, 32'd0);

        // 4: redirect in HOLD with id_ready the same cycle drops the instruction
        do_reset();
        mem_lat = 0;
        push(32'h0AA0_0084, 32'h0000_0080);
        start = 1'b1;
        cyc(2);
        bus.id_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0080;
        cyc(1);
        redirect = 1'b0;
        chk("t4_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("t4_req", {31'd0, bus.imem_req}, 32'd1);
        chk("t4_addr", bus.imem_addr, 32'h0000_0080);
        start = 1'b0;
        cyc(4);
        chk("t4_pc", pc, 32'h0000_0084);

        // 5: PC wrap from 0xFFFFFFFC, start dropped mid-REQ
        do_reset();
        start_w = 1'b1;
        cyc(1);
        chk("t5_req", {31'd0, bus_w.imem_req}, 32'd1);
        chk("t5_addr", bus_w.imem_addr, 32'hFFFF_FFFC);
        start_w = 1'b0;
        cyc(1);
        chk("t5_valid", {31'd0, bus_w.instr_valid}, 32'd1);
        chk("t5_instr", bus_w.instr, 32'h1234_5678);
        chk("t5_ipc", bus_w.instr_pc, 32'hFFFF_FFFC);
        chk("t5_pc_wrap", pc_w, 32'h0000_0000);
        cyc(1);
        chk("t5_drained", {31'd0, bus_w.instr_valid}, 32'd0);
        chk("t5_idle", {31'd0, bus_w.imem_req}, 32'd0);

        // 6: misaligned redirect
        do_reset();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0042;
        cyc(1);
        redirect = 1'b0;
        bus.id_ready = 1'b1;
`ifdef MISALIGN_CHK_EN
        chk("t6_pc", pc, 32'h0000_0042);
        chk("t6_fault", {31'd0, fetch_fault}, 32'd1);
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("t6_noreq", {31'd0, bus.imem_req}, 32'd0);
        end
        chk("t6_sticky", {31'd0, fetch_fault}, 32'd1);
        start = 1'b0;
`else
        chk("t6_pc", pc, 32'h0000_0040);
        chk("t6_fault", {31'd0, fetch_fault}, 32'd0);
        push(32'h0AA0_0044, 32'h0000_0040);
        start = 1'b1;
        cyc(1);
        chk("t6_req", {31'd0, bus.imem_req}, 32'd1);
        chk("t6_addr", bus.imem_addr, 32'h0000_0040);
        start = 1'b0;
        cyc(3);
        chk("t6_pc_after", pc, 32'h0000_0044);
`endif
        cyc(2);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
